// File: rtl/msi_irq_arbiter.sv
// Round-robin sharing of the PCIe core MSI request/grant port between NUM_SRC edge-triggered sources.
// Optional build macro MSI_IRQ_MASK_EN adds a per-source irq_mask input that excludes sources from arbitration.
module msi_irq_arbiter #(
  parameter int NUM_SRC        = 8,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               msi_enable,
  input  logic [2:0]         msi_mmenable,
`ifdef MSI_IRQ_MASK_EN
  input  logic [NUM_SRC-1:0] irq_mask,
`endif
  output logic               intx_msi_request,
  input  logic               intx_msi_grant,
  output logic [4:0]         msi_vector_num,
  output logic [NUM_SRC-1:0] irq_pending,
  output logic               busy,
  output logic [1:0]         o_dbg_state
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_SRC-1:0] r_irq_q;
  logic               r_hist_valid;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_clr;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      w_ptr_nxt;
  logic [PW-1:0]      w_sel;
  logic               w_found;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nxt;
  logic               r_req;
  logic               w_req_nxt;
  logic [4:0]         r_vec;
  logic [4:0]         w_vec_nxt;
  logic [4:0]         w_vmask;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_SRC) sum = sum - NUM_SRC;
    return PW'(sum);
  endfunction

  // History is not trusted on the first edge after reset, so a line already high then raises no event.
  assign w_rise = irq_in & ~r_irq_q & {NUM_SRC{r_hist_valid}};

`ifdef MSI_IRQ_MASK_EN
  assign w_elig = r_pending & ~irq_mask;
`else
  assign w_elig = r_pending;
`endif

  assign w_vmask = (msi_mmenable >= 3'd5) ? 5'h1F : 5'((6'd1 << msi_mmenable) - 6'd1);

  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!w_found && w_elig[wrap_idx(r_ptr, k)]) begin
        w_found = 1'b1;
        w_sel   = wrap_idx(r_ptr, k);
      end
    end
  end

  // Handshake: request rises with a stable vector and both hold until a cycle with grant=1;
  // that cycle completes the transfer and request is low from the next cycle. Grant outside REQ is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_vec_nxt   = r_vec;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_clr       = '0;
    case (r_state)
      S_IDLE: begin
        if (msi_enable && w_found) begin
          w_state_nxt = S_REQ;
          w_req_nxt   = 1'b1;
          w_vec_nxt   = 5'(w_sel) & w_vmask;
          w_ptr_nxt   = w_sel;
        end
      end
      S_REQ: begin
        if (intx_msi_grant) begin
          w_req_nxt    = 1'b0;
          w_clr[r_ptr] = 1'b1;
          if (HOLDOFF_CYCLES == 0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_HOLDOFF;
            w_cnt_nxt   = CW'(HOLDOFF_CYCLES);
          end
        end
      end
      S_HOLDOFF: begin
        if (r_cnt <= CW'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_q      <= '0;
      r_hist_valid <= 1'b0;
      r_pending    <= '0;
      r_ptr        <= PW'(NUM_SRC - 1);
      r_cnt        <= '0;
      r_req        <= 1'b0;
      r_vec        <= '0;
    end else begin
      r_irq_q      <= irq_in;
      r_hist_valid <= 1'b1;
      // Set wins over clear so an edge coinciding with the grant becomes a fresh event.
      r_pending    <= (r_pending & ~w_clr) | w_rise;
      r_ptr        <= w_ptr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_req        <= w_req_nxt;
      r_vec        <= w_vec_nxt;
    end
  end

  assign intx_msi_request = r_req;
  assign msi_vector_num   = r_vec;
  assign irq_pending      = r_pending;
  assign busy             = (r_state != S_IDLE);
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_msi_irq_arbiter.sv
// Scoreboarded bench for msi_irq_arbiter: directed scenarios plus randomized bursts against a round-robin model.
module tb_msi_irq_arbiter;

  localparam int N    = 8;
  localparam int HOLD = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] irq_in = '0;
  logic         msi_enable = 1'b1;
  logic [2:0]   msi_mmenable = 3'd3;
  logic         intx_msi_request;
  logic         intx_msi_grant;
  logic [4:0]   msi_vector_num;
  logic [N-1:0] irq_pending;
  logic         busy;
  logic [1:0]   dbg_state;
`ifdef MSI_IRQ_MASK_EN
  logic [N-1:0] irq_mask = '0;
`endif

  logic gnt_auto = 1'b0;
  logic gnt_man  = 1'b0;
  bit   gnt_en   = 1'b1;
  int   gnt_delay = 0;
  int   burst_id  = 0;
  int   cyc       = 0;
  int   n_cmp     = 0;
  int   n_err     = 0;
  int   model_last = N - 1;
  logic [4:0] exp_q[$];

  assign intx_msi_grant = gnt_auto | gnt_man;

  msi_irq_arbiter #(.NUM_SRC(N), .HOLDOFF_CYCLES(HOLD)) dut (
    .clk              (clk),
    .rst              (rst),
    .irq_in           (irq_in),
    .msi_enable       (msi_enable),
    .msi_mmenable     (msi_mmenable),
`ifdef MSI_IRQ_MASK_EN
    .irq_mask         (irq_mask),
`endif
    .intx_msi_request (intx_msi_request),
    .intx_msi_grant   (intx_msi_grant),
    .msi_vector_num   (msi_vector_num),
    .irq_pending      (irq_pending),
    .busy             (busy),
    .o_dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: round-robin order is "first set bit strictly after the last served source, with wrap".
  function automatic int first_after(input logic [N-1:0] s);
    for (int k = 1; k <= N; k++) begin
      if (s[(model_last + k) % N]) return (model_last + k) % N;
    end
    return -1;
  endfunction

  function automatic void expect_rr(input logic [N-1:0] s, input logic [2:0] mm);
    int m;
    int last_i;
    m = (int'(mm) > 5) ? 5 : int'(mm);
    last_i = model_last;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (model_last + k) % N;
      if (s[idx]) begin
        exp_q.push_back(5'(idx % (1 << m)));
        last_i = idx;
      end
    end
    model_last = last_i;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse(input logic [N-1:0] mask);
    @(negedge clk);
    irq_in = mask;
    @(negedge clk);
    irq_in = '0;
  endtask

  task automatic wait_req(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (intx_msi_request) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !intx_msi_request && irq_pending == '0) break;
    end
    check({name, "_drained"}, 32'(i < 3000), 32'd1);
  endtask

  // Core-side grant responder: grants after gnt_delay extra cycles of request.
  initial begin : grant_driver
    int wait_left;
    wait_left = -1;
    forever begin
      @(negedge clk);
      gnt_auto = 1'b0;
      if (gnt_en && intx_msi_request && !rst) begin
        if (wait_left < 0) wait_left = gnt_delay;
        if (wait_left == 0) begin
          gnt_auto  = 1'b1;
          wait_left = -1;
        end else begin
          wait_left--;
        end
      end else begin
        wait_left = -1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic       prev_req;
    logic [4:0] held_vec;
    int         last_rise;
    int         last_burst;
    prev_req   = 1'b0;
    held_vec   = '0;
    last_rise  = 0;
    last_burst = -1;
    forever begin
      @(negedge clk);
      if (intx_msi_request && !prev_req) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_request: vector %0d arrived with empty expected queue", msi_vector_num);
        end else begin
          check("msi_vector", 32'(msi_vector_num), 32'(exp_q.pop_front()));
        end
        if (last_burst == burst_id) check("req_spacing", cyc - last_rise, HOLD + 2 + gnt_delay);
        last_burst = burst_id;
        last_rise  = cyc;
        held_vec   = msi_vector_num;
      end else if (intx_msi_request) begin
        check("vector_stable", 32'(msi_vector_num), 32'(held_vec));
      end
      prev_req = intx_msi_request;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    bit           ok;
    bit           seen;
    int           cnt;
    int           f;
    logic [N-1:0] s;
    logic [N-1:0] m;

    // Reset with src6 held high across release: no event may result.
    irq_in = 8'h40;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_request", 32'(intx_msi_request), 32'd0);
    check("rst_vector", 32'(msi_vector_num), 32'd0);
    check("rst_pending", 32'(irq_pending), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("held_high_no_pending", 32'(irq_pending), 32'd0);
    check("held_high_no_request", 32'(intx_msi_request), 32'd0);
    irq_in = '0;
    @(negedge clk);

    // Single event on src3: latency, grant after 4 request cycles, holdoff length.
    burst_id++;
    msi_mmenable = 3'd3;
    gnt_delay    = 3;
    expect_rr(8'h08, 3'd3);
    @(negedge clk);
    irq_in = 8'h08;
    @(negedge clk);
    irq_in = '0;
    check("t1_pending3", 32'(irq_pending[3]), 32'd1);
    check("t1_no_req_yet", 32'(intx_msi_request), 32'd0);
    @(negedge clk);
    check("t1_req_latency", 32'(intx_msi_request), 32'd1);
    cnt = 1;
    while (intx_msi_request && cnt < 20) begin
      @(negedge clk);
      if (intx_msi_request) cnt++;
    end
    check("t1_req_cycles", cnt, gnt_delay + 1);
    check("t1_pending3_cleared", 32'(irq_pending[3]), 32'd0);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("t1_holdoff_busy", cnt, HOLD);

    // All sources at once after reset: served 0..7, then again with mmenable=0 (all vector 0).
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst        = 1'b0;
    model_last = N - 1;
    @(negedge clk);
    burst_id++;
    gnt_delay    = 0;
    msi_mmenable = 3'd3;
    expect_rr(8'hFF, 3'd3);
    pulse(8'hFF);
    drain("t2_mm3");
    burst_id++;
    msi_mmenable = 3'd0;
    expect_rr(8'hFF, 3'd0);
    pulse(8'hFF);
    drain("t2_mm0");

    // msi_enable=0 holds the event; enabling releases it.
    burst_id++;
    msi_mmenable = 3'd3;
    msi_enable   = 1'b0;
    expect_rr(8'h20, 3'd3);
    pulse(8'h20);
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (intx_msi_request) seen = 1'b1;
    end
    check("t3_no_req_disabled", 32'(seen), 32'd0);
    check("t3_pending5", 32'(irq_pending[5]), 32'd1);
    msi_enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (intx_msi_request) begin
        ok = 1'b1;
        break;
      end
    end
    check("t3_req_after_enable", 32'(ok), 32'd1);
    drain("t3");

    // Re-edge on src2 in its own grant cycle must produce a second MSI.
    burst_id++;
    gnt_en    = 1'b0;
    gnt_delay = 0;
    expect_rr(8'h04, 3'd3);
    pulse(8'h04);
    wait_req(10, ok);
    check("t4_first_req", 32'(ok), 32'd1);
    gnt_man = 1'b1;
    irq_in  = 8'h04;
    @(negedge clk);
    gnt_man = 1'b0;
    irq_in  = '0;
    check("t4_req_dropped", 32'(intx_msi_request), 32'd0);
    check("t4_pending2_kept", 32'(irq_pending[2]), 32'd1);
    exp_q.push_back(5'd2);
    gnt_en = 1'b1;
    drain("t4");

    // Stray grant while idle is ignored.
    gnt_man = 1'b1;
    @(negedge clk);
    gnt_man = 1'b0;
    @(negedge clk);
    check("stray_grant_busy", 32'(busy), 32'd0);
    check("stray_grant_request", 32'(intx_msi_request), 32'd0);

    // Reset while in REQ loses the in-flight and the queued event.
    burst_id++;
    gnt_en = 1'b0;
    f = first_after(8'h42);
    exp_q.push_back(5'(f % 8));
    pulse(8'h42);
    wait_req(10, ok);
    check("t5_req", 32'(ok), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_req_dropped", 32'(intx_msi_request), 32'd0);
    check("t5_pending_lost", 32'(irq_pending), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    rst        = 1'b0;
    model_last = N - 1;
    gnt_en     = 1'b1;
    seen       = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (intx_msi_request) seen = 1'b1;
    end
    check("t5_no_req_after_reset", 32'(seen), 32'd0);

`ifdef MSI_IRQ_MASK_EN
    // Masked src1 latches but waits; unmasking during holdoff lets it follow src4.
    burst_id++;
    gnt_delay = 0;
    irq_mask  = 8'h02;
    expect_rr(8'h10, 3'd3);
    pulse(8'h12);
    wait_req(10, ok);
    check("t6_req4", 32'(ok), 32'd1);
    check("t6_pending1_masked", 32'(irq_pending[1]), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!intx_msi_request) break;
    end
    irq_mask = '0;
    expect_rr(8'h02, 3'd3);
    drain("t6");
`endif

    // Randomized bursts with merged re-edges on still-pending sources.
    for (int it = 0; it < 25; it++) begin
      burst_id++;
      s            = N'($urandom_range(1, 255));
      msi_mmenable = 3'($urandom_range(0, 7));
      gnt_delay    = int'($urandom_range(0, 3));
      f            = first_after(s);
      m            = N'($urandom) & s & ~(N'(1) << f);
      expect_rr(s, msi_mmenable);
      @(negedge clk);
      irq_in = s;
      @(negedge clk);
      irq_in = '0;
      @(negedge clk);
      irq_in = m;
      @(negedge clk);
      irq_in = '0;
      drain("rand");
    end

    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
